// File: rtl/spi_regs_pkg.sv
// -----------------------------------------------------------------------------
// spi_regs_pkg
// Shared definitions for the SPI register bank: register count, the clear
// command (address/key pair), the FSM state encoding and small decode helpers.
// -----------------------------------------------------------------------------
package spi_regs_pkg;

  localparam int         NUM_REGS   = 8;
  localparam logic [7:0] CLEAR_ADDR = 8'hFF;
  localparam logic [7:0] CLEAR_KEY  = 8'hA5;

  // Frame handling FSM encoding; also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Address selects one of the writable registers.
  function automatic logic is_reg_addr(input logic [7:0] addr);
    return addr < 8'(NUM_REGS);
  endfunction

  // Whole word is the clear-all command.
  function automatic logic is_clear_cmd(input logic [15:0] word);
    return (word[15:8] == CLEAR_ADDR) && (word[7:0] == CLEAR_KEY);
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// -----------------------------------------------------------------------------
// cdc_sync
// Multi-flop synchronizer for a single asynchronous level signal.
// Parameters:
//   STAGES    - number of flops in the chain (2 or more)
//   RESET_VAL - value every flop takes while rst_n is low
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input level
//   q     out synchronized level (output of the last flop)
// -----------------------------------------------------------------------------
module cdc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift toward the MSB; bit 0 is the first (metastable-capturing) flop.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Eight 8-bit registers written from SPI words. The rising edge of spi_cs
// (synchronized into clk) marks a frame end; after SETTLE_CYC cycles the word
// on spi_data ([15:8] address, [7:0] data) is latched and committed:
//   address 0..7      -> write register, one-cycle wr_stb with wr_addr
//   0xFF with 0xA5    -> clear all registers, no wr_stb
//   anything else     -> discarded
// One further frame may queue while a frame is in flight; more are dropped.
//
// Optional feature macro: SPI_REG_BANK_ERRCNT_EN adds err_cnt, a saturating
// count of discarded and dropped words, cleared by the clear command.
//
// Parameters:
//   SYNC_STAGES - spi_cs synchronizer depth (>= 2)
//   SETTLE_CYC  - cycles from frame event to data latch (1..15)
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   spi_cs     in  SPI chip select (asynchronous)
//   spi_data   in  last received SPI word
//   regs       out flattened registers, reg N at [8N+7:8N]
//   wr_stb     out one-cycle pulse per committed register write
//   wr_addr    out written register index, qualified by wr_stb
//   busy       out high while the FSM is not idle
//   err_cnt    out error counter (only with SPI_REG_BANK_ERRCNT_EN)
//   dbg_state  out current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic [15:0] spi_data,
  output logic [63:0] regs,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic        busy,
`ifdef SPI_REG_BANK_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  // ---------------------------------------------------------------------------
  // Frame event: 0->1 on the synchronized chip select. The previous-value flop
  // resets high like the synchronizer, so a cs held high through reset release
  // never looks like an edge.
  // ---------------------------------------------------------------------------
  logic cs_sync;
  logic cs_prev_q, cs_prev_d;
  logic frame_evt;

  cdc_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (spi_cs),
    .q     (cs_sync)
  );

  assign cs_prev_d = cs_sync;
  assign frame_evt = cs_sync & ~cs_prev_q;

  // ---------------------------------------------------------------------------
  // FSM and datapath state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic in_commit;
  logic cmd_write;
  logic cmd_clear;

  assign in_commit = (state_q == ST_COMMIT);
  assign cmd_write = in_commit & is_reg_addr(word_q[15:8]);
  assign cmd_clear = in_commit & is_clear_cmd(word_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_evt) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaching zero on this edge: latch the word now so that the
        // commit cycle lands SETTLE_CYC cycles after the SETTLE entry.
        if (cnt_q == 4'd1) begin
          word_d  = spi_data;
          state_d = ST_COMMIT;
        end
        // A second event while pending is already set leaves it set (dropped).
        if (frame_evt) begin
          pend_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        // An event arriving in the commit cycle itself starts the next frame
        // directly; if a frame was already pending, that event is dropped.
        if (pend_q || frame_evt) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (cmd_clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = 8'h00;
      end
    end else if (cmd_write) begin
      regs_d[word_q[10:8]] = word_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 1'b0;
      word_q    <= 16'h0000;
      cs_prev_q <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      word_q    <= word_d;
      cs_prev_q <= cs_prev_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. wr_addr is only meaningful while wr_stb is high and is held at 0
  // otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    regs = 64'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[8*i +: 8] = regs_q[i];
    end
  end

  assign wr_stb    = cmd_write;
  assign wr_addr   = cmd_write ? word_q[10:8] : 3'd0;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef SPI_REG_BANK_ERRCNT_EN
  // ---------------------------------------------------------------------------
  // Error counter. pend_q is never set in IDLE, so an event with pend_q high
  // is exactly a dropped event. A discard and a drop can coincide in the
  // commit cycle, hence the two-term add before saturation.
  // ---------------------------------------------------------------------------
  logic       cmd_discard;
  logic       drop_evt;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  assign cmd_discard = in_commit & ~cmd_write & ~cmd_clear;
  assign drop_evt    = frame_evt & pend_q;

  always_comb begin
    err_sum = {1'b0, err_cnt_q} + 9'(cmd_discard) + 9'(drop_evt);
    if (cmd_clear) begin
      err_cnt_d = 8'h00;
    end else if (err_sum > 9'd255) begin
      err_cnt_d = 8'hFF;
    end else begin
      err_cnt_d = err_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank
// Bench for spi_reg_bank with default parameters. A frame-level model
// schedules each chip-select rise as a commit cycle (or a drop), and the
// outputs are compared against it every cycle. Directed frames pin the model
// with hand-computed values, then randomized frames follow.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;

  localparam int SYNC = 2;   // synchronizer depth (DUT default)
  localparam int S    = 2;   // settle cycles (DUT default)
  localparam int HIST = 8192;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_cs;
  logic [15:0] spi_data;
  logic [63:0] regs;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef SPI_REG_BANK_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_data  (spi_data),
    .regs      (regs),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .busy      (busy),
`ifdef SPI_REG_BANK_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and frame-level model
  //   exp_q   : commit cycles of accepted frames, oldest first
  //   drop_q  : cycles at which an event was dropped
  //   hist    : spi_data driven in each cycle
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] drop_q[$];
  logic [15:0] hist [HIST];
  logic [7:0]  m_regs [8];
  int          m_err;
  logic        last_cs;
  int          stb_cnt = 0;
  int          last_stb_cyc = -1;
  logic [15:0] cur_data = 16'h0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    drop_q.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_err   = 0;
    last_cs = 1'b1;
  endtask

  // Event at cycle t: accepted if fewer than two frames are still unfinished.
  // A queued frame starts right after its predecessor commits.
  task automatic model_event(input int t);
    int outstanding;
    outstanding = 0;
    foreach (exp_q[i]) if (int'(exp_q[i]) >= t) outstanding++;
    if (outstanding == 0)      exp_q.push_back(32'(t + S + 1));
    else if (outstanding == 1) exp_q.push_back(exp_q[$] + 32'(S + 1));
    else                       drop_q.push_back(32'(t));
  endtask

  // Per-cycle compare of every output against the model, then advance the
  // model's register/error state by what this cycle commits.
  task automatic cycle_check();
    logic [63:0] exp_regs;
    logic        commit_now, exp_stb, exp_busy;
    logic [15:0] w;
    int          drops;
    for (int i = 0; i < 8; i++) exp_regs[8*i +: 8] = m_regs[i];
    commit_now = (exp_q.size() > 0) && (int'(exp_q[0]) == cyc);
    exp_busy = 1'b0;
    foreach (exp_q[i]) if (int'(exp_q[i]) - S <= cyc && int'(exp_q[i]) >= cyc) exp_busy = 1'b1;
    w       = commit_now ? hist[(cyc - 1) % HIST] : 16'h0000;
    exp_stb = commit_now && (w[15:8] < 8'd8);

    check("regs", regs, exp_regs);
    check("busy", 64'(busy), 64'(exp_busy));
    check("wr_stb", 64'(wr_stb), 64'(exp_stb));
    if (exp_stb) check("wr_addr", 64'(wr_addr), 64'(w[10:8]));
`ifdef SPI_REG_BANK_ERRCNT_EN
    check("err_cnt", 64'(err_cnt), 64'(m_err));
`endif
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      last_stb_cyc = cyc;
    end

    drops = 0;
    while (drop_q.size() > 0 && int'(drop_q[0]) == cyc) begin
      void'(drop_q.pop_front());
      drops++;
    end
    if (commit_now) begin
      void'(exp_q.pop_front());
      if (exp_stb) m_regs[w[10:8]] = w[7:0];
      else if (w == 16'hFFA5) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_err = 0;
        drops = 0;
      end else drops++;
    end
    m_err = (m_err + drops > 255) ? 255 : m_err + drops;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one call per clock cycle, acting on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic cs, input logic [15:0] data, input logic rst);
    @(negedge clk);
    cyc++;
    cycle_check();
    reset_n  = rst;
    spi_cs   = cs;
    spi_data = data;
    hist[cyc % HIST] = data;
    if (!rst) begin
      model_reset();
    end else begin
      if (cs && !last_cs) model_event(cyc + SYNC);
      last_cs = cs;
    end
  endtask

  // Frame: cs low for lo cycles, then rises with the new word held for hi.
  task automatic send(input logic [15:0] word, input int lo, input int hi);
    repeat (lo) step(1'b0, cur_data, 1'b1);
    cur_data = word;
    repeat (hi) step(1'b1, cur_data, 1'b1);
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    r = $urandom_range(0, 99);
    if (r < 62)      return {5'd0, 3'($urandom_range(0, 7)), 8'($urandom)};
    else if (r < 70) return 16'hFFA5;
    else if (r < 82) return {8'hFF, 8'($urandom_range(0, 164))};
    else             return {8'($urandom_range(8, 254)), 8'($urandom)};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int rc, base, gaps;
    reset_n  = 1'b0;
    spi_cs   = 1'b1;
    spi_data = 16'h0000;
    model_reset();

    // Reset with cs held high, released with cs still high: no frame event.
    repeat (3) step(1'b1, 16'h0000, 1'b0);
    check("rst_regs", regs, 64'h0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stb", 64'(wr_stb), 64'd0);
    repeat (8) step(1'b1, 16'h0000, 1'b1);
    check("cs_high_release_stb", 64'(stb_cnt), 64'd0);
    check("cs_high_release_busy", 64'(busy), 64'd0);

    // Single frame 0x0342: wr_stb exactly SYNC + 3 cycles after the cs rise.
    base = stb_cnt;
    send(16'h0342, 2, 1);
    rc = cyc;
    repeat (8) step(1'b1, cur_data, 1'b1);
    check("lat_0342", 64'(last_stb_cyc - rc), 64'd5);
    check("stb_once_0342", 64'(stb_cnt - base), 64'd1);
    check("reg3_0342", 64'(regs[31:24]), 64'h42);

    // Two writes then clear-all.
    send(16'h0011, 2, 8);
    send(16'h07EE, 2, 8);
    check("reg0_11", 64'(regs[7:0]), 64'h11);
    check("reg7_ee", 64'(regs[63:56]), 64'hEE);
    base = stb_cnt;
    send(16'hFFA5, 2, 8);
    check("clear_regs", regs, 64'h0);
    check("clear_no_stb", 64'(stb_cnt - base), 64'd0);

    // Invalid address and wrong clear key are discarded.
    base = stb_cnt;
    send(16'h0812, 2, 8);
    send(16'hFF00, 2, 8);
    check("discard_regs", regs, 64'h0);
    check("discard_no_stb", 64'(stb_cnt - base), 64'd0);
`ifdef SPI_REG_BANK_ERRCNT_EN
    check("discard_err_cnt", 64'(err_cnt), 64'd2);
`endif

    // Second rise during SETTLE (word replaced by 0x0155): both frames commit
    // back-to-back to reg1 with busy high from rc+3 to rc+8.
    base = stb_cnt;
    gaps = 0;
    send(16'h0210, 2, 1);
    rc = cyc;
    step(1'b0, cur_data, 1'b1);
    cur_data = 16'h0155;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, cur_data, 1'b1);
      if (cyc >= rc + 3 && cyc <= rc + 8 && busy !== 1'b1) gaps++;
    end
    check("b2b_busy_gaps", 64'(gaps), 64'd0);
    check("b2b_stb_count", 64'(stb_cnt - base), 64'd2);
    check("b2b_reg1", 64'(regs[15:8]), 64'h55);

    // Reset pulse during SETTLE of frame 0x0299: frame abandoned.
    base = stb_cnt;
    send(16'h0299, 2, 4);
    check("settle_busy", 64'(busy), 64'd1);
    repeat (2) step(1'b1, cur_data, 1'b0);
    repeat (8) step(1'b1, cur_data, 1'b1);
    check("abandon_reg2", 64'(regs[23:16]), 64'h00);
    check("abandon_no_stb", 64'(stb_cnt - base), 64'd0);
    check("abandon_busy", 64'(busy), 64'd0);

    // Randomized frames with short gaps so queued frames occur often.
    for (int n = 0; n < 300; n++) begin
      send(rand_word(), $urandom_range(1, 3), $urandom_range(1, 10));
    end
    repeat (12) step(1'b0, cur_data, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
